rng_health_monitor: RTL and testbench

- Downstream consumer of the LFSR random-word stream. Runs continuous health tests on every word: a repetition count test (RCT) and an adaptive proportion test (APT).
- Discards a startup block of words, then buffers passing words in a small FIFO for the crypto consumer.
- On any test failure it latches an alarm, flushes the FIFO and blocks output until software clears the alarm.

---
 rtl/rng_health_monitor.sv | 140 ++++++++++++++
 tb/tb_rng_health_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rng_health_monitor.sv
// Continuous health monitor for a random-word stream: repetition count and adaptive proportion
// tests, startup discard, and a small output FIFO that is flushed and blocked on any alarm.
module rng_health_monitor #(
    parameter int WIDTH           = 32,
    parameter int RCT_CUTOFF      = 4,
    parameter int APT_WINDOW      = 64,
    parameter int APT_CUTOFF      = 56,
    parameter int STARTUP_SAMPLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             alarm_clear,
    output logic             alarm_rct,
    output logic             alarm_apt,
    output logic [15:0]      drop_count,
    output logic [1:0]       state
);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int AW = $clog2(APT_WINDOW);
    localparam int MW = $clog2(APT_WINDOW + 1);
    localparam int SW = $clog2(STARTUP_SAMPLES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [RW-1:0] RCT_LIM = RW'(RCT_CUTOFF);
    localparam logic [MW-1:0] APT_LIM = MW'(APT_CUTOFF);
    localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_SAMPLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Debug encoding exported on the state port: 0=STARTUP, 1=RUN, 2=ALARM.
    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    state_t           st;
    logic [WIDTH-1:0] last;
    logic             have_last;
    logic [RW-1:0]    rep, rep_nxt;
    logic [AW-1:0]    apt_idx;
    logic             apt_ref;
    logic [MW-1:0]    match, match_nxt;
    logic [SW-1:0]    su_cnt;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             testing, rct_fail, apt_fail, fail, full, pop, push, drop;

    assign state     = st;
    assign out_valid = (st == ST_RUN) && (count != '0);
    assign out_data  = mem[rd_ptr];

    always_comb begin
        testing   = in_valid && (st != ST_ALARM);
        rep_nxt   = (have_last && in_data == last) ? rep + RW'(1) : RW'(1);
        match_nxt = (apt_idx == '0) ? MW'(1) : match + MW'(in_data[0] == apt_ref);
        rct_fail  = testing && (rep_nxt == RCT_LIM);
        apt_fail  = testing && (match_nxt == APT_LIM);
        fail      = rct_fail || apt_fail;
        full      = (count == FULL_CNT);
        pop       = out_valid && out_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push      = testing && !fail && (st == ST_RUN) && (!full || pop);
        drop      = testing && !fail && (st == ST_RUN) && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= ST_STARTUP;
            last       <= '0;
            have_last  <= 1'b0;
            rep        <= '0;
            apt_idx    <= '0;
            apt_ref    <= 1'b0;
            match      <= '0;
            su_cnt     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            alarm_rct  <= 1'b0;
            alarm_apt  <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            case (st)
                ST_STARTUP, ST_RUN: begin
                    if (testing) begin
                        last      <= in_data;
                        have_last <= 1'b1;
                        rep       <= rep_nxt;
                        match     <= match_nxt;
                        apt_idx   <= apt_idx + AW'(1);
                        if (apt_idx == '0) apt_ref <= in_data[0];
                        if (st == ST_STARTUP) su_cnt <= su_cnt + SW'(1);
                        if (fail) begin
                            st        <= ST_ALARM;
                            alarm_rct <= alarm_rct | rct_fail;
                            alarm_apt <= alarm_apt | apt_fail;
                        end else if (st == ST_STARTUP && su_cnt == SU_LAST) begin
                            st <= ST_RUN;
                        end
                    end
                end
                default: begin
                    if (alarm_clear) begin
                        st        <= ST_STARTUP;
                        alarm_rct <= 1'b0;
                        alarm_apt <= 1'b0;
                        have_last <= 1'b0;
                        rep       <= '0;
                        apt_idx   <= '0;
                        match     <= '0;
                        su_cnt    <= '0;
                    end
                end
            endcase

            if (fail) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end

            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_rng_health_monitor.sv
// Randomized bench for rng_health_monitor against a sample-history reference model.
module tb_rng_health_monitor;
    localparam int W     = 32;
    localparam int RCT   = 4;
    localparam int APT_W = 64;
    localparam int APT_C = 56;
    localparam int SU    = 16;
    localparam int DEPTH = 4;
    localparam logic [1:0] S_STARTUP = 2'd0, S_RUN = 2'd1, S_ALARM = 2'd2;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready, alarm_clear;
    logic [W-1:0] in_data, out_data;
    logic         out_valid, alarm_rct, alarm_apt;
    logic [15:0]  drop_count;
    logic [1:0]   state;

    rng_health_monitor #(
        .WIDTH(W), .RCT_CUTOFF(RCT), .APT_WINDOW(APT_W), .APT_CUTOFF(APT_C),
        .STARTUP_SAMPLES(SU), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .alarm_clear(alarm_clear), .alarm_rct(alarm_rct), .alarm_apt(alarm_apt),
        .drop_count(drop_count), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: the words waiting for the consumer, the recent sample history and
    // the bit0 values of the current APT window.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] hist[$];
    logic         win[$];
    logic [1:0]   m_state;
    logic         m_rct, m_apt;
    int           m_drop;
    int           n_samp;
    int           n_cmp = 0;
    int           n_mis = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_restart();
        hist.delete();
        win.delete();
        n_samp = 0;
    endtask

    task automatic check_status();
        check("alarm_rct", W'(alarm_rct), W'(m_rct));
        check("alarm_apt", W'(alarm_apt), W'(m_apt));
        check("drop_count", W'(drop_count), W'(m_drop));
        check("state", W'(state), W'(m_state));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; alarm_clear = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; alarm_clear = 1'b0;
        m_state = S_STARTUP; m_rct = 1'b0; m_apt = 1'b0; m_drop = 0;
        exp_q.delete();
        model_restart();
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
        check_status();
    endtask

    // One clock cycle: drive inputs, check outputs seen before the edge, advance the model.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic c);
        logic ev, rf, af;
        int   m;
        in_valid = v; in_data = d; out_ready = r; alarm_clear = c;
        ev = (m_state == S_RUN) && (exp_q.size() > 0);
        check("out_valid", W'(out_valid), W'(ev));
        if (ev) check("out_data", out_data, exp_q[0]);
        if (m_state == S_ALARM) begin
            if (c) begin
                m_state = S_STARTUP; m_rct = 1'b0; m_apt = 1'b0;
                model_restart();
            end
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > RCT) void'(hist.pop_front());
            rf = (hist.size() == RCT);
            for (int i = 0; i < hist.size(); i++) if (hist[i] != d) rf = 1'b0;
            win.push_back(d[0]);
            m = 0;
            for (int i = 0; i < win.size(); i++) if (win[i] == win[0]) m++;
            af = (m == APT_C) && (d[0] == win[0]);
            if (win.size() == APT_W) win.delete();
            n_samp++;
            if (rf || af) begin
                m_rct = m_rct | rf; m_apt = m_apt | af;
                m_state = S_ALARM;
                exp_q.delete();
            end else if (m_state == S_STARTUP) begin
                if (n_samp == SU) m_state = S_RUN;
            end else begin
                if (ev && r) void'(exp_q.pop_front());
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                else if (m_drop < 65535) m_drop++;
            end
        end else if (ev && r) begin
            void'(exp_q.pop_front());
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; alarm_clear = 1'b0;
        check_status();
    endtask

    task automatic startup_fill();
        for (int i = 0; i < SU; i++) step(1'b1, $urandom, 1'b1, 1'b0);
    endtask

    logic [W-1:0] prev;
    logic [W-1:0] w;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; alarm_clear = 1'b0;
        @(negedge clk); @(negedge clk);
        do_reset();

        // Startup discard, then ordered pass-through; alarm_clear in RUN must be ignored.
        startup_fill();
        check("in_run", W'(state), W'(S_RUN));
        for (int i = 1; i <= 12; i++) step(1'b1, 32'hA5A5_0000 + W'(i), 1'b1, (i == 5));
        step(1'b0, '0, 1'b1, 1'b0);

        // Overflow: six passing samples into a stalled FIFO, then full with push and pop together.
        for (int i = 0; i < 6; i++) step(1'b1, 32'hC0DE_0000 + W'(i), 1'b0, 1'b0);
        check("drop_after_ovf", W'(drop_count), W'(2));
        step(1'b1, 32'hC0DE_0010, 1'b1, 1'b0);
        check("drop_push_pop_full", W'(drop_count), W'(2));
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

        // RCT trip, samples ignored in ALARM, then clear and restart.
        for (int i = 0; i < 2; i++) step(1'b1, 32'hBEEF_0000 + W'(i), 1'b0, 1'b0);
        for (int i = 0; i < RCT; i++) step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check("rct_tripped", W'(alarm_rct), W'(1));
        for (int i = 0; i < 5; i++) step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);

        // APT: window of 55 matches wraps without alarm, next window trips on the 56th match.
        for (int i = 0; i < APT_W; i++) begin
            w = (i < APT_C - 1) ? W'(2 * i + 1) : W'(2 * i + 1000);
            step(1'b1, w, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("apt_no_trip", W'(alarm_apt), W'(0));
        for (int i = 0; i < APT_C; i++) step(1'b1, W'(2 * i + 5001), 1'($urandom_range(0, 1)), 1'b0);
        check("apt_tripped", W'(alarm_apt), W'(1));
        step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic with occasional repeats and clears.
        prev = $urandom;
        for (int i = 0; i < 600; i++) begin
            w = ($urandom_range(0, 4) == 0) ? prev : $urandom;
            prev = w;
            step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));
        end

        // Reset mid-RUN with three words buffered.
        do_reset();
        startup_fill();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h7777_0000 + W'(i), 1'b0, 1'b0);
        check("three_buffered", W'(out_valid), W'(1));
        do_reset();
        check("post_reset_state", W'(state), W'(S_STARTUP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
